// File: rtl/burst_prod.sv
// burst_prod: ready/valid burst traffic producer with LFSR-drawn burst lengths and pauses.
// Define PROD_STATS_EN to build the completed-burst counter; otherwise burst_cnt is tied to 0.
module burst_prod #(
    parameter int          DATA_W    = 8,
    parameter int          MIN_BURST = 3,
    parameter int          MAX_BURST = 5,
    parameter int          MIN_PAUSE = 1,
    parameter int          MAX_PAUSE = 4,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              rdy,
    output logic              val,
    output logic [DATA_W-1:0] data,
    output logic              last,
    output logic [15:0]       burst_cnt
);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? 16'h0001 : SEED;
    localparam int BR = MAX_BURST - MIN_BURST + 1;
    localparam int PR = MAX_PAUSE - MIN_PAUSE + 1;

    typedef enum logic [1:0] {IDLE, BURST, PAUSE} state_t;

    state_t            state;
    logic [15:0]       lfsr, lfsr_nx;
    logic [7:0]        len_d, pause_d, beats_left, pcnt;
    logic [DATA_W-1:0] inc;
    logic              mode_q, start, acc;

    assign lfsr_nx = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    assign len_d   = 8'(MIN_BURST + int'(lfsr[7:0]) % BR);
    assign pause_d = 8'(MIN_PAUSE + int'(lfsr[15:8]) % PR);
    // a burst may begin from IDLE or on the final pause cycle
    assign start   = en && (state == IDLE || (state == PAUSE && pcnt == 8'd1));
    assign acc     = state == BURST && val && rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= SEED_EFF;
            val        <= 1'b0;
            data       <= '0;
            last       <= 1'b0;
            beats_left <= '0;
            pcnt       <= '0;
            inc        <= '0;
            mode_q     <= 1'b0;
        end else begin
            lfsr <= lfsr_nx;
            if (acc && mode_q) inc <= inc + 1'b1;
            if (start) begin
                state      <= BURST;
                val        <= 1'b1;
                last       <= len_d == 8'd1;
                beats_left <= len_d;
                mode_q     <= mode;
                data       <= mode ? inc : lfsr[DATA_W-1:0];
            end else if (acc && last) begin
                state <= PAUSE;
                val   <= 1'b0;
                last  <= 1'b0;
                pcnt  <= pause_d;
            end else if (acc) begin
                beats_left <= beats_left - 8'd1;
                last       <= beats_left == 8'd2;
                data       <= mode_q ? inc + 1'b1 : lfsr[DATA_W-1:0];
            end else if (state == PAUSE) begin
                if (pcnt == 8'd1) state <= IDLE;
                else pcnt <= pcnt - 8'd1;
            end
        end
    end

`ifdef PROD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) burst_cnt <= '0;
        else if (acc && last) burst_cnt <= burst_cnt + 16'd1;
    end
`else
    assign burst_cnt = '0;
`endif

endmodule

// File: tb/tb_burst_prod.sv
// tb_burst_prod: scoreboard bench for burst_prod; dut_a is a fixed 4-beat/2-pause 4-bit
// instance for directed tests, dut_b uses default parameters for the randomised LFSR run.
module tb_burst_prod;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_a = 1'b0, mode_a = 1'b0, rdy_a = 1'b1;
    logic        en_b = 1'b0, mode_b = 1'b0, rdy_b = 1'b1;
    logic        val_a, last_a, val_b, last_b;
    logic [3:0]  data_a;
    logic [7:0]  data_b;
    logic [15:0] cnt_a, cnt_b;
    logic [15:0] m_lfsr, m_prev;
    logic [3:0]  dq[$];
    logic        lq[$];
    int          pass_cnt = 0;
    int          total = 0;

`ifdef PROD_STATS_EN
    localparam logic [15:0] EXP_BURSTS = 16'd10;
`else
    localparam logic [15:0] EXP_BURSTS = 16'd0;
`endif

    burst_prod #(.DATA_W(4), .MIN_BURST(4), .MAX_BURST(4), .MIN_PAUSE(2), .MAX_PAUSE(2)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .rdy(rdy_a),
        .val(val_a), .data(data_a), .last(last_a), .burst_cnt(cnt_a)
    );

    burst_prod dut_b (
        .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .rdy(rdy_b),
        .val(val_b), .data(data_b), .last(last_b), .burst_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    // reference LFSR; m_prev holds the value seen by the most recent load edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        end
    end

    task automatic do_reset;
        rst = 1'b1;
        en_a = 1'b0;
        en_b = 1'b0;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        dq.delete();
        lq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        @(negedge clk);
        total++;
        if ({val_a, data_a, last_a, cnt_a} !== '0)
            $display("FAIL reset_a: val=%b data=%0d last=%b cnt=%0d, expected all 0", val_a, data_a, last_a, cnt_a);
        else pass_cnt++;
        total++;
        if ({val_b, data_b, last_b, cnt_b} !== '0)
            $display("FAIL reset_b: val=%b data=%0d last=%b cnt=%0d, expected all 0", val_b, data_b, last_b, cnt_b);
        else pass_cnt++;
    endtask

    task automatic test_stream;
        int         gap = 0;
        logic       seen = 1'b0;
        logic [3:0] ed;
        logic       el;
        do_reset;
        mode_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dq.push_back(4'(i));
            lq.push_back(i % 4 == 3);
        end
        en_a = 1'b1;
        for (int c = 0; c < 60 && dq.size() > 0; c++) begin
            @(negedge clk);
            if (val_a) begin
                if (seen && gap > 0) begin
                    total++;
                    if (gap != 2) $display("FAIL stream_gap: got %0d idle cycles, expected 2", gap);
                    else pass_cnt++;
                    gap = 0;
                end
                seen = 1'b1;
                ed = dq.pop_front();
                el = lq.pop_front();
                total++;
                if (data_a !== ed || last_a !== el)
                    $display("FAIL stream_beat: data=%0d last=%b, expected data=%0d last=%b", data_a, last_a, ed, el);
                else pass_cnt++;
            end else if (seen) gap++;
        end
        total++;
        if (dq.size() != 0) $display("FAIL stream_timeout: %0d beats missing, expected 0", dq.size());
        else pass_cnt++;
        en_a = 1'b0;
    endtask

    task automatic test_backpressure;
        int         stall = 0;
        logic [3:0] ed;
        logic       el;
        do_reset;
        mode_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dq.push_back(4'(i));
            lq.push_back(i == 3);
        end
        en_a = 1'b1;
        for (int c = 0; c < 40 && dq.size() > 0; c++) begin
            @(negedge clk);
            if (stall > 0 && stall < 3) begin
                total++;
                if (val_a !== 1'b1 || data_a !== 4'd1)
                    $display("FAIL bp_hold: val=%b data=%0d, expected val=1 data=1", val_a, data_a);
                else pass_cnt++;
                stall++;
            end else if (stall == 0 && val_a && data_a == 4'd1) begin
                rdy_a = 1'b0;
                stall = 1;
            end else begin
                rdy_a = 1'b1;
                if (val_a) begin
                    ed = dq.pop_front();
                    el = lq.pop_front();
                    total++;
                    if (data_a !== ed || last_a !== el)
                        $display("FAIL bp_beat: data=%0d last=%b, expected data=%0d last=%b", data_a, last_a, ed, el);
                    else pass_cnt++;
                end
            end
        end
        total++;
        if (dq.size() != 0) $display("FAIL bp_timeout: %0d beats missing, expected 0", dq.size());
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (val_a !== 1'b0) $display("FAIL bp_extra: val=%b after last beat, expected 0", val_a);
        else pass_cnt++;
        en_a = 1'b0;
    endtask

    task automatic test_en_drop;
        logic [3:0] ed;
        logic       el;
        do_reset;
        mode_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dq.push_back(4'(i));
            lq.push_back(i == 3);
        end
        en_a = 1'b1;
        for (int c = 0; c < 30 && dq.size() > 0; c++) begin
            @(negedge clk);
            if (val_a) begin
                if (data_a == 4'd1) en_a = 1'b0;
                ed = dq.pop_front();
                el = lq.pop_front();
                total++;
                if (data_a !== ed || last_a !== el)
                    $display("FAIL en_beat: data=%0d last=%b, expected data=%0d last=%b", data_a, last_a, ed, el);
                else pass_cnt++;
            end
        end
        total++;
        if (dq.size() != 0) $display("FAIL en_timeout: %0d beats missing, expected 0", dq.size());
        else pass_cnt++;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++;
            if (val_a !== 1'b0) $display("FAIL en_idle: val=%b at cycle %0d with en=0, expected 0", val_a, k);
            else pass_cnt++;
        end
        en_a = 1'b1;
        @(negedge clk);
        total++;
        if (val_a !== 1'b1 || data_a !== 4'd4)
            $display("FAIL en_restart: val=%b data=%0d, expected val=1 data=4", val_a, data_a);
        else pass_cnt++;
        en_a = 1'b0;
    endtask

    task automatic test_wrap;
        logic [3:0] ed;
        logic       el;
        do_reset;
        mode_a = 1'b1;
        for (int i = 0; i < 20; i++) begin
            dq.push_back(4'(i));
            lq.push_back(i % 4 == 3);
        end
        en_a = 1'b1;
        for (int c = 0; c < 120 && dq.size() > 0; c++) begin
            @(negedge clk);
            if (val_a) begin
                ed = dq.pop_front();
                el = lq.pop_front();
                total++;
                if (data_a !== ed || last_a !== el)
                    $display("FAIL wrap_beat: data=%0d last=%b, expected data=%0d last=%b", data_a, last_a, ed, el);
                else pass_cnt++;
            end
        end
        total++;
        if (dq.size() != 0) $display("FAIL wrap_timeout: %0d beats missing, expected 0", dq.size());
        else pass_cnt++;
        en_a = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic hit = 1'b0;
        do_reset;
        mode_a = 1'b1;
        en_a = 1'b1;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (val_a && data_a == 4'd3) hit = 1'b1;
        end
        total++;
        if (!hit) $display("FAIL rmid_timeout: beat 3 seen=%b, expected 1", hit);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total++;
        if ({val_a, data_a, last_a} !== '0)
            $display("FAIL rmid_clear: val=%b data=%0d last=%b, expected all 0", val_a, data_a, last_a);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (val_a !== 1'b1 || data_a !== 4'd0 || last_a !== 1'b0)
            $display("FAIL rmid_first: val=%b data=%0d last=%b, expected val=1 data=0 last=0", val_a, data_a, last_a);
        else pass_cnt++;
        en_a = 1'b0;
    endtask

    task automatic test_stats;
        int n = 0;
        do_reset;
        mode_a = 1'b0;
        en_a = 1'b1;
        for (int c = 0; c < 200 && n < 10; c++) begin
            @(negedge clk);
            if (val_a && last_a) n++;
            if (n == 10) en_a = 1'b0;
        end
        total++;
        if (n != 10) $display("FAIL stats_timeout: %0d bursts seen, expected 10", n);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (cnt_a !== EXP_BURSTS) $display("FAIL stats_cnt: burst_cnt=%0d, expected %0d", cnt_a, EXP_BURSTS);
        else pass_cnt++;
        en_a = 1'b0;
    endtask

    task automatic test_random;
        int   beat = 0, gap = 0, cur = 0, bursts = 0, pexp = 0;
        logic pv = 1'b0;
        int   lenq[$], pq[$];
        do_reset;
        mode_b = 1'b0;
        en_b = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (val_b) begin
                if (!pv) begin
                    lenq.push_back(3 + int'(m_prev[7:0]) % 3);
                    if (pq.size() > 0) begin
                        pexp = pq.pop_front();
                        total++;
                        if (gap != pexp || gap < 1 || gap > 4)
                            $display("FAIL rand_gap: got %0d idle cycles, expected %0d", gap, pexp);
                        else pass_cnt++;
                    end
                    beat = 0;
                end
                beat++;
                total++;
                if (data_b !== m_prev[7:0] || last_b !== (beat == lenq[0]))
                    $display("FAIL rand_beat: data=%0h last=%b, expected data=%0h last=%b",
                             data_b, last_b, m_prev[7:0], beat == lenq[0]);
                else pass_cnt++;
            end else begin
                if (pv) begin
                    cur = lenq.pop_front();
                    total++;
                    if (beat != cur || beat < 3 || beat > 5)
                        $display("FAIL rand_len: got %0d beats, expected %0d", beat, cur);
                    else pass_cnt++;
                    bursts++;
                    pq.push_back(1 + int'(m_prev[15:8]) % 4);
                    gap = 0;
                end
                gap++;
            end
            pv = val_b;
        end
        total++;
        if (bursts < 100) $display("FAIL rand_bursts: %0d bursts completed, expected at least 100", bursts);
        else pass_cnt++;
        en_b = 1'b0;
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_en_drop;
        test_wrap;
        test_reset_mid;
        test_stats;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
